keypad_entry: RTL and testbench
===============================

KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000: consecutive cycles a synchronized button must differ from its debounced level before that level flips; legal range 1..65535.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port btn_inc, input, 1: raw asynchronous button, increment selected digit.
REQ-005 SHALL have port btn_next, input, 1: raw asynchronous button, toggle selected digit.
REQ-006 SHALL have port btn_enter, input, 1: raw asynchronous button, commit entry.
REQ-007 SHALL have port out_ready, input, 1: consumer (datapath) accepts out_value.
REQ-008 SHALL have port out_value, output, 32: committed binary value.
REQ-009 SHALL have port out_valid, output, 1: out_value holds an unaccepted commit.
REQ-010 SHALL have port digit_ones, output, 4: BCD ones digit being edited.
REQ-011 SHALL have port digit_tens, output, 4: BCD tens digit being edited.
REQ-012 SHALL have port sel, output, 1: 0 = ones selected, 1 = tens selected.

Function
REQ-013 SHALL pass each raw button through a two-flop synchronizer before any other use.
REQ-014 SHALL keep, per button, a debounce counter: it increments while the synchronized value differs from the debounced level and clears to 0 when they match.
REQ-015 SHALL flip the debounced level on the edge where the counter would reach DEBOUNCE_CYCLES, and clear the counter on that same edge.
REQ-016 SHALL generate a registered one-cycle press pulse on each debounced 0->1 transition only; releases generate no event; a held button yields exactly one press.
REQ-017 SHALL show a press pulse exactly DEBOUNCE_CYCLES+3 cycles after the first edge sampling a clean raw rise; glitches shorter than DEBOUNCE_CYCLES synchronized cycles produce no pulse.
REQ-018 SHALL implement FSM states EDIT and HOLD, with reset state EDIT.
REQ-019 In EDIT, an inc press SHALL increment the selected digit modulo 10 (9 wraps to 0); the other digit is unchanged.
REQ-020 In EDIT, a next press SHALL toggle sel.
REQ-021 In EDIT, an enter press SHALL, on that edge, load out_value = digit_tens*10 + digit_ones, zero-extended to 32 bits; set out_valid=1; and move to HOLD.
REQ-022 SHALL NOT clear or change the digits or sel on commit.
REQ-023 For press pulses in the same cycle, SHALL apply priority enter > next > inc; lower-priority presses in that cycle are discarded.
REQ-024 In HOLD, SHALL discard all presses, with no queuing.
REQ-025 In HOLD, SHALL hold out_value stable.
REQ-026 In HOLD, when out_ready=1 at an edge, SHALL clear out_valid on that edge and return to EDIT; a press on that same edge is discarded.
REQ-027 With out_valid=0, SHALL ignore out_ready; out_ready may be tied high, giving a one-cycle valid pulse per commit.
REQ-028 SHALL retain out_value after acceptance until the next commit.
REQ-029 SHALL drive all outputs from registers, with no combinational path from inputs to outputs.

Reset
REQ-030 On rst=1 at an edge, SHALL set out_value=0, out_valid=0, digit_ones=0, digit_tens=0, sel=0, FSM=EDIT, all synchronizers, debounced levels and counters=0, and all press pulses=0.
REQ-031 rst SHALL override every simultaneous event, including during HOLD: a pending valid is dropped without handshake.
REQ-032 A button held high across reset release SHALL produce one press DEBOUNCE_CYCLES+3 cycles after release.

Verification
REQ-033 DEBOUNCE_CYCLES=4; after reset, clean btn_inc rise held 20 cycles -> one press pulse 7 cycles after first sampling edge; digit_ones=1.
REQ-034 Seven inc presses, next press, 4 inc presses, enter, out_ready=0 -> out_value=47, out_valid=1 held; further inc presses leave digit_tens=4 and digit_ones=7.
REQ-035 From REQ-034 state, assert out_ready for 1 cycle -> out_valid=0 next cycle, out_value stays 47, FSM=EDIT; next inc makes digit_tens=5.
REQ-036 ones=9, inc press -> ones=0, tens unchanged; btn_inc glitch of 3 synchronized cycles -> no press.
REQ-037 Enter and inc pulses forced in the same cycle with digits 2/3 -> out_value=23, digits unchanged.
REQ-038 Assert rst while out_valid=1 -> all outputs 0 next cycle; out_ready afterwards has no effect.

Source files
------------

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - two-digit BCD keypad entry with debounced buttons and valid/ready commit
// Buttons are synchronized, debounced and edge-detected before reaching the EDIT/HOLD FSM.
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_inc,
  input  logic        btn_next,
  input  logic        btn_enter,
  input  logic        out_ready,
  output logic [31:0] out_value,
  output logic        out_valid,
  output logic [3:0]  digit_ones,
  output logic [3:0]  digit_tens,
  output logic        sel
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    EDIT = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Button index: 0 = inc, 1 = next, 2 = enter
  logic [2:0]  sync1_q;
  logic [2:0]  sync2_q;
  logic [2:0]  level_q;
  logic [2:0]  prev_q;
  logic [2:0]  pulse_q;
  logic [15:0] cnt_q [3];

  state_t      state_q;
  logic [31:0] out_value_q;
  logic        out_valid_q;
  logic [3:0]  ones_q;
  logic [3:0]  tens_q;
  logic        sel_q;

  logic [7:0]  commit_d;
  logic [3:0]  ones_d;
  logic [3:0]  tens_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= {btn_enter, btn_next, btn_inc};
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          // Counter would reach DEBOUNCE_CYCLES on this edge: accept the new level.
          cnt_q[i]   <= '0;
          level_q[i] <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
      prev_q  <= level_q;
      pulse_q <= level_q & ~prev_q;
    end
  end

  always_comb begin
    commit_d = ({4'd0, tens_q} * 8'd10) + {4'd0, ones_q};
    ones_d   = (ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1;
    tens_d   = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EDIT;
      out_value_q <= '0;
      out_valid_q <= 1'b0;
      ones_q      <= '0;
      tens_q      <= '0;
      sel_q       <= 1'b0;
    end else begin
      case (state_q)
        EDIT: begin
          // Priority enter > next > inc; lower-priority presses in the same cycle are dropped.
          if (pulse_q[2]) begin
            out_value_q <= {24'd0, commit_d};
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else if (pulse_q[1]) begin
            sel_q <= ~sel_q;
          end else if (pulse_q[0]) begin
            if (sel_q) begin
              tens_q <= tens_d;
            end else begin
              ones_q <= ones_d;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= EDIT;
          end
        end
        default: state_q <= EDIT;
      endcase
    end
  end

  assign out_value  = out_value_q;
  assign out_valid  = out_valid_q;
  assign digit_ones = ones_q;
  assign digit_tens = tens_q;
  assign sel        = sel_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - scoreboard bench for keypad_entry with randomized button presses
module tb_keypad_entry;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_inc, btn_next, btn_enter, out_ready;
  logic [31:0] out_value;
  logic        out_valid;
  logic [3:0]  digit_ones, digit_tens;
  logic        sel;

  int total = 0;
  int passed = 0;

  int m_ones, m_tens, m_sel, m_hold, m_value;
  int exp_q[$];
  logic prev_valid = 1'b0;

  keypad_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_next(btn_next), .btn_enter(btn_enter),
    .out_ready(out_ready), .out_value(out_value), .out_valid(out_valid),
    .digit_ones(digit_ones), .digit_tens(digit_tens), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every new commit presented by the DUT is matched against the scoreboard.
  always @(negedge clk) begin
    if (out_valid && !prev_valid) begin
      if (exp_q.size() == 0) check("unexpected_commit", int'(out_value), -1);
      else check("commit_value", int'(out_value), exp_q.pop_front());
    end
    prev_valid = out_valid;
  end

  task automatic model_press(input int mask);
    if (m_hold != 0) return;
    if (mask[2]) begin
      m_value = m_tens * 10 + m_ones;
      m_hold  = 1;
      exp_q.push_back(m_value);
    end else if (mask[1]) begin
      m_sel = 1 - m_sel;
    end else if (mask[0]) begin
      if (m_sel != 0) m_tens = (m_tens + 1) % 10;
      else m_ones = (m_ones + 1) % 10;
    end
  endtask

  task automatic model_reset();
    m_ones = 0; m_tens = 0; m_sel = 0; m_hold = 0; m_value = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_ones"}, int'(digit_ones), m_ones);
    check({tag, "_tens"}, int'(digit_tens), m_tens);
    check({tag, "_sel"}, int'(sel), m_sel);
    check({tag, "_valid"}, int'(out_valid), m_hold);
    check({tag, "_value"}, int'(out_value), m_value);
  endtask

  task automatic press(input int mask);
    model_press(mask);
    btn_inc   = mask[0];
    btn_next  = mask[1];
    btn_enter = mask[2];
    tick(D + 6);
    btn_inc = 1'b0; btn_next = 1'b0; btn_enter = 1'b0;
    tick(D + 6);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    m_hold = 0;
  endtask

  initial begin
    rst = 1'b1; btn_inc = 1'b0; btn_next = 1'b0; btn_enter = 1'b0; out_ready = 1'b0;
    model_reset();
    tick(3);
    rst = 1'b0;
    tick();
    check_state("reset");

    // Latency: digit update lands D+3 edges after the first edge sampling the rise.
    btn_inc = 1'b1;
    tick();
    tick(D + 2);
    check("latency_before", int'(digit_ones), 0);
    tick();
    check("latency_at", int'(digit_ones), 1);
    tick(20 - (D + 3));
    btn_inc = 1'b0;
    tick(D + 6);
    model_press(1);
    check_state("single_press");

    repeat (6) press(1);
    press(2);
    repeat (4) press(1);
    out_ready = 1'b0;
    press(4);
    check_state("commit47");
    check("commit47_value_abs", int'(out_value), 47);
    press(1);
    press(2);
    check_state("hold_discard");

    accept();
    check_state("accepted");
    press(1);
    check("tens_after_accept", int'(digit_tens), 5);

    press(2);
    press(1); press(1);
    check("ones_nine", int'(digit_ones), 9);
    press(1);
    check_state("ones_wrap");

    btn_inc = 1'b1;
    tick(3);
    btn_inc = 1'b0;
    tick(D + 8);
    check_state("glitch");

    press(2);
    repeat (7) press(1);
    press(2);
    repeat (3) press(1);
    press(5);
    check_state("enter_inc_same");
    check("enter_inc_value_abs", int'(out_value), 23);
    accept();

    press(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_state("reset_in_hold");
    out_ready = 1'b1;
    tick(3);
    out_ready = 1'b0;
    check_state("ready_after_reset");

    for (int i = 0; i < 50; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (m_hold != 0 && r < 4) accept();
      else if (r < 4) press(1);
      else if (r < 6) press(2);
      else if (r < 8) press(4);
      else press(int'($urandom_range(3, 7)));
      check_state("random");
    end
    if (m_hold != 0) accept();
    tick(2);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
